// File: rtl/axi_wr_slave.sv
// axi_wr_slave: single-outstanding AXI write slave driving a word-wide memory port.
//   Accepts one AW, consumes len+1 W beats (one per cycle), issues one B response.
//   Each accepted beat produces a registered one-cycle memory write (mem_we) unless
//   the burst has picked up an error, in which case beats are consumed but not written.
// Ports:
//   clock, reset_n (async, active-low)
//   aw_*  : write address channel (aw_lock/cache/prot/user accepted and ignored)
//   w_*   : write data channel
//   b_*   : write response channel (b_resp 0 = OKAY, 2 = SLVERR)
//   mem_* : memory write strobe, word index, data and byte enables
// Configuration:
//   AXI_WR_SLAVE_WRAP_EN : when defined, WRAP bursts are supported; otherwise a
//                          WRAP burst is consumed without writing and answered SLVERR.
module axi_wr_slave #(
   parameter int unsigned AXI_WR_ID_WIDTH   = 8,
   parameter int unsigned AXI_WR_ADDR_WIDTH = 32,
   parameter int unsigned AXI_WR_BUS_WIDTH  = 32,
   parameter int unsigned MEM_ADDR_WIDTH    = 10,
   parameter logic [AXI_WR_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [AXI_WR_ID_WIDTH-1:0]      aw_id,
   input  logic [AXI_WR_ADDR_WIDTH-1:0]    aw_addr,
   input  logic [3:0]                      aw_len,
   input  logic [2:0]                      aw_size,
   input  logic [1:0]                      aw_burst,
   input  logic [1:0]                      aw_lock,
   input  logic [3:0]                      aw_cache,
   input  logic [2:0]                      aw_prot,
   input  logic [4:0]                      aw_user,
   input  logic                            aw_valid,
   output logic                            aw_ready,
   input  logic [AXI_WR_ID_WIDTH-1:0]      w_id,
   input  logic [AXI_WR_BUS_WIDTH-1:0]     w_data,
   input  logic [AXI_WR_BUS_WIDTH/8-1:0]   w_strb,
   input  logic                            w_last,
   input  logic                            w_valid,
   output logic                            w_ready,
   output logic [AXI_WR_ID_WIDTH-1:0]      b_id,
   output logic [1:0]                      b_resp,
   output logic                            b_valid,
   input  logic                            b_ready,
   output logic                            mem_we,
   output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
   output logic [AXI_WR_BUS_WIDTH-1:0]     mem_wdata,
   output logic [AXI_WR_BUS_WIDTH/8-1:0]   mem_be
);

   localparam int unsigned AW  = AXI_WR_ADDR_WIDTH;
   localparam int unsigned BB  = AXI_WR_BUS_WIDTH / 8;
   localparam int unsigned BL  = $clog2(BB);
   localparam int unsigned WIN = MEM_ADDR_WIDTH + BL;   // log2 of window size in bytes
   localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t                            state_q;
   logic                              aw_ready_q, w_ready_q, b_valid_q, mem_we_q, err_q;
   logic [AXI_WR_ID_WIDTH-1:0]        id_q, b_id_q;
   logic [AW-1:0]                     addr_q;
   logic [3:0]                        len_q, beat_cnt_q;
   logic [2:0]                        size_q;
   logic [1:0]                        burst_q, b_resp_q;
   logic [MEM_ADDR_WIDTH-1:0]         mem_addr_q;
   logic [AXI_WR_BUS_WIDTH-1:0]       mem_wdata_q;
   logic [AXI_WR_BUS_WIDTH/8-1:0]     mem_be_q;

   logic                              aw_err_d, beat_err_d, last_d;
   logic [AW-1:0]                     aw_bytes, beat_bytes, aligned, addr_d;
   logic [MEM_ADDR_WIDTH-1:0]         mem_idx_d;
`ifdef AXI_WR_SLAVE_WRAP_EN
   logic [AW-1:0]                     wrap_size, wrap_low;
`endif

   logic unused_ok;
   assign unused_ok = ^{aw_lock, aw_cache, aw_prot, aw_user, 1'b0};

   // Address falls inside [BASE_ADDR, BASE_ADDR + 2^WIN).
   function automatic logic in_window(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ((off >> WIN) == '0);
   endfunction

   always_comb begin
      aw_bytes = A_ONE << aw_size;
      aw_err_d = !in_window(aw_addr) || (aw_size > 3'(BL)) || (aw_burst == 2'd3);
`ifdef AXI_WR_SLAVE_WRAP_EN
      if ((aw_burst == 2'd2) &&
          (((aw_addr & (aw_bytes - A_ONE)) != '0) || !(aw_len inside {4'd1, 4'd3, 4'd7, 4'd15})))
         aw_err_d = 1'b1;
`else
      if (aw_burst == 2'd2)
         aw_err_d = 1'b1;
`endif

      beat_bytes = A_ONE << size_q;
      aligned    = addr_q & ~(beat_bytes - A_ONE);
      last_d     = (beat_cnt_q == len_q);
`ifdef AXI_WR_SLAVE_WRAP_EN
      wrap_size  = ({{(AW-4){1'b0}}, len_q} + A_ONE) << size_q;
      wrap_low   = addr_q & ~(wrap_size - A_ONE);
`endif
      case (burst_q)
         2'd1:    addr_d = aligned + beat_bytes;
`ifdef AXI_WR_SLAVE_WRAP_EN
         2'd2:    addr_d = wrap_low + ((addr_q + beat_bytes) & (wrap_size - A_ONE));
`endif
         default: addr_d = addr_q;
      endcase

      // Sticky error: includes this beat's own address/protocol faults so the
      // offending beat itself is not written.
      beat_err_d = err_q || !in_window(addr_q) || (w_last != last_d) || (w_id != id_q);
      mem_idx_d  = MEM_ADDR_WIDTH'((addr_q - BASE_ADDR) >> BL);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         aw_ready_q  <= 1'b0;
         w_ready_q   <= 1'b0;
         b_valid_q   <= 1'b0;
         b_resp_q    <= '0;
         b_id_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (aw_valid && aw_ready_q) begin
                  id_q       <= aw_id;
                  addr_q     <= aw_addr;
                  len_q      <= aw_len;
                  size_q     <= aw_size;
                  burst_q    <= aw_burst;
                  beat_cnt_q <= '0;
                  err_q      <= aw_err_d;
                  aw_ready_q <= 1'b0;
                  w_ready_q  <= 1'b1;
                  state_q    <= DATA;
               end else begin
                  aw_ready_q <= 1'b1;
               end
            end
            DATA: begin
               if (w_valid && w_ready_q) begin
                  mem_addr_q  <= mem_idx_d;
                  mem_wdata_q <= w_data;
                  mem_be_q    <= w_strb;
                  mem_we_q    <= !beat_err_d && (w_strb != '0);
                  addr_q      <= addr_d;
                  beat_cnt_q  <= beat_cnt_q + 4'd1;
                  err_q       <= beat_err_d;
                  if (last_d) begin
                     w_ready_q <= 1'b0;
                     b_valid_q <= 1'b1;
                     b_id_q    <= id_q;
                     b_resp_q  <= beat_err_d ? 2'd2 : 2'd0;
                     state_q   <= RESP;
                  end
               end
            end
            RESP: begin
               if (b_ready && b_valid_q) begin
                  b_valid_q  <= 1'b0;
                  aw_ready_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign aw_ready  = aw_ready_q;
   assign w_ready   = w_ready_q;
   assign b_valid   = b_valid_q;
   assign b_id      = b_id_q;
   assign b_resp    = b_resp_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// tb_axi_wr_slave: randomized and directed bench for axi_wr_slave with a
// burst-level reference model (beat addresses computed arithmetically).
module tb_axi_wr_slave;

   localparam int unsigned IDW = 8;
   localparam int unsigned AWD = 32;
   localparam int unsigned BW  = 32;
   localparam int unsigned MAW = 10;
   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam longint unsigned WIN_BYTES = 64'd4096;   // 2^MAW words * 4 bytes
`ifdef AXI_WR_SLAVE_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   logic           clock = 1'b0;
   logic           reset_n;
   logic [IDW-1:0] aw_id;
   logic [AWD-1:0] aw_addr;
   logic [3:0]     aw_len;
   logic [2:0]     aw_size;
   logic [1:0]     aw_burst, aw_lock;
   logic [3:0]     aw_cache;
   logic [2:0]     aw_prot;
   logic [4:0]     aw_user;
   logic           aw_valid, aw_ready;
   logic [IDW-1:0] w_id;
   logic [BW-1:0]  w_data;
   logic [BW/8-1:0] w_strb;
   logic           w_last, w_valid, w_ready;
   logic [IDW-1:0] b_id;
   logic [1:0]     b_resp;
   logic           b_valid, b_ready;
   logic           mem_we;
   logic [MAW-1:0] mem_addr;
   logic [BW-1:0]  mem_wdata;
   logic [BW/8-1:0] mem_be;

   axi_wr_slave #(
      .AXI_WR_ID_WIDTH(IDW), .AXI_WR_ADDR_WIDTH(AWD), .AXI_WR_BUS_WIDTH(BW),
      .MEM_ADDR_WIDTH(MAW), .BASE_ADDR(BASE)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
      .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
      .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
      .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [MAW-1:0]  idx;
      logic [BW-1:0]   data;
      logic [BW/8-1:0] be;
   } wr_t;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   always @(negedge clock)
      if (mem_we) obs_q.push_back(wr_t'({mem_addr, mem_wdata, mem_be}));

   function automatic bit in_win(input longint unsigned a);
      return (a >= longint'(BASE)) && (a < longint'(BASE) + WIN_BYTES);
   endfunction

   // Drives one complete burst, predicts its writes/response and checks them.
   // bad_last / bad_id_beat select a beat with a flipped w_last / wrong w_id (-1: none).
   task automatic run_burst(input string tag, input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input bit rnd, input int bad_last, input int bad_id_beat, input int stall);
      logic [31:0] dat[16];
      logic [3:0]  stb[16];
      logic [7:0]  wid[16];
      logic        wl[16];
      bit          err, hs;
      longint unsigned bytes, bsize, lower, a;
      logic [1:0]  exp_resp;
      int          wcyc;
      int          nmin;

      bytes = 64'd1 << size;
      err = !in_win(addr) || (size > 3'd2) || (burst == 2'd3) || (burst == 2'd2 && !WRAP_EN);
      if (burst == 2'd2 && WRAP_EN && (((addr % bytes) != 0) || !(len inside {4'd1, 4'd3, 4'd7, 4'd15})))
         err = 1'b1;
      exp_q.delete();
      for (int k = 0; k <= int'(len); k++) begin
         dat[k] = rnd ? $urandom : 32'(k + 1);
         stb[k] = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
         wid[k] = (k == bad_id_beat) ? (id ^ 8'h5A) : id;
         wl[k]  = (k == int'(len)) ^ (k == bad_last);
         case (burst)
            2'd0: a = addr;
            2'd1: a = (k == 0) ? addr : (addr / bytes) * bytes + longint'(k) * bytes;
            default: begin
               bsize = (longint'(len) + 1) * bytes;
               lower = (addr / bsize) * bsize;
               a = lower + ((addr - lower) + longint'(k) * bytes) % bsize;
            end
         endcase
         if (!in_win(a) || (wl[k] != (k == int'(len))) || (wid[k] != id)) err = 1'b1;
         if (!err && stb[k] != 4'h0)
            exp_q.push_back(wr_t'({10'((a - BASE) / 4), dat[k], stb[k]}));
      end
      exp_resp = err ? 2'd2 : 2'd0;
      obs_q.delete();

      aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
      aw_lock = 2'($urandom); aw_cache = 4'($urandom); aw_prot = 3'($urandom); aw_user = 5'($urandom);
      aw_valid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge clock); hs = aw_ready; @(posedge clock); #1;
      end
      aw_valid = 1'b0;
      n_cmp++;
      if (!hs) begin n_err++; $display("FAIL %s aw_accept: aw_ready not seen in 20 cycles", tag); end

      wcyc = 0;
      for (int k = 0; k <= int'(len); k++) begin
         w_id = wid[k]; w_data = dat[k]; w_strb = stb[k]; w_last = wl[k]; w_valid = 1'b1;
         hs = 1'b0;
         for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge clock); hs = w_ready; @(posedge clock); #1; wcyc++;
         end
      end
      w_valid = 1'b0; w_last = 1'b0;
      n_cmp++;
      if (wcyc != int'(len) + 1) begin
         n_err++; $display("FAIL %s w_cycles: got %0d need %0d", tag, wcyc, int'(len) + 1);
      end

      hs = 1'b0;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge clock); hs = b_valid;
         if (!hs) begin @(posedge clock); #1; end
      end
      n_cmp++;
      if (!hs) begin n_err++; $display("FAIL %s b_valid: not seen in 20 cycles", tag); end
      n_cmp++;
      if (b_resp !== exp_resp || b_id !== id) begin
         n_err++; $display("FAIL %s b_resp/b_id: got %0d/%h need %0d/%h", tag, b_resp, b_id, exp_resp, id);
      end
      for (int d = 0; d < stall; d++) begin
         @(posedge clock); #1; @(negedge clock);
         n_cmp++;
         if ({b_valid, aw_ready, w_ready} !== 3'b100) begin
            n_err++; $display("FAIL %s stall%0d b_valid/aw_ready/w_ready: got %b need 100", tag, d,
                              {b_valid, aw_ready, w_ready});
         end
      end
      @(posedge clock); #1; b_ready = 1'b1;
      @(posedge clock); #1; b_ready = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({b_valid, aw_ready} !== 2'b01) begin
         n_err++; $display("FAIL %s after_b b_valid/aw_ready: got %b need 01", tag, {b_valid, aw_ready});
      end

      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL %s write_count: got %0d need %0d", tag, obs_q.size(), exp_q.size());
      end
      nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL %s write%0d idx/data/be: got %h/%h/%h need %h/%h/%h", tag, i,
                              obs_q[i].idx, obs_q[i].data, obs_q[i].be, exp_q[i].idx, exp_q[i].data, exp_q[i].be);
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      n_cmp++;
      if ({aw_ready, w_ready, b_valid, b_resp, b_id, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
         n_err++; $display("FAIL reset outputs: got nonzero %b/%b/%b/%h/%h/%b/%h/%h/%h need all 0",
                           aw_ready, w_ready, b_valid, b_resp, b_id, mem_we, mem_addr, mem_wdata, mem_be);
      end
      @(negedge clock); reset_n = 1'b1;
      #1;
      n_cmp++;
      if (aw_ready !== 1'b0) begin n_err++; $display("FAIL reset aw_ready_before_edge: got %b need 0", aw_ready); end
      @(posedge clock); #1;
      n_cmp++;
      if ({aw_ready, w_ready, b_valid} !== 3'b100) begin
         n_err++; $display("FAIL reset first_edge aw/w/b: got %b need 100", {aw_ready, w_ready, b_valid});
      end
   endtask

   task automatic test_incr();
      run_burst("incr_req", 8'h3C, BASE + 32'h10, 4'd3, 3'd2, 2'd1, 1'b0, -1, -1, 0);
      run_burst("incr_rand", 8'hA5, BASE + 32'h200, 4'd15, 3'd2, 2'd1, 1'b1, -1, -1, 0);
      run_burst("incr_byte", 8'h11, BASE + 32'h101, 4'd7, 3'd0, 2'd1, 1'b1, -1, -1, 0);
   endtask

   task automatic test_fixed();
      run_burst("fixed_req", 8'h07, BASE + 32'h8, 4'd2, 3'd2, 2'd0, 1'b0, -1, -1, 0);
   endtask

   task automatic test_wrap();
      run_burst("wrap_req", 8'h42, BASE + 32'h38, 4'd3, 3'd2, 2'd2, 1'b0, -1, -1, 0);
      run_burst("wrap_badlen", 8'h43, BASE + 32'h40, 4'd2, 3'd2, 2'd2, 1'b0, -1, -1, 0);
   endtask

   task automatic test_errors();
      run_burst("oow_addr", 8'h01, BASE + 32'h1000, 4'd0, 3'd2, 2'd1, 1'b0, -1, -1, 0);
      run_burst("early_last", 8'h02, BASE + 32'h20, 4'd3, 3'd2, 2'd1, 1'b0, 1, -1, 0);
      run_burst("bad_wid", 8'h03, BASE + 32'h30, 4'd3, 3'd2, 2'd1, 1'b0, -1, 2, 0);
      run_burst("big_size", 8'h04, BASE + 32'h40, 4'd1, 3'd3, 2'd1, 1'b0, -1, -1, 0);
      run_burst("burst3", 8'h05, BASE + 32'h50, 4'd1, 3'd2, 2'd3, 1'b0, -1, -1, 0);
      run_burst("cross_top", 8'h06, BASE + 32'hFF8, 4'd3, 3'd2, 2'd1, 1'b0, -1, -1, 0);
      run_burst("below_base", 8'h08, BASE - 32'h4, 4'd0, 3'd2, 2'd1, 1'b0, -1, -1, 0);
   endtask

   task automatic test_bready_stall();
      run_burst("stall5", 8'h99, BASE + 32'h80, 4'd1, 3'd2, 2'd1, 1'b1, -1, -1, 5);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_burst("b2b", 8'($urandom), BASE + 32'($urandom_range(0, 255) * 4), 4'($urandom_range(0, 15)),
                   3'd2, 2'd1, 1'b1, -1, -1, 0);
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int sel;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 7);
         if (sel == 0)      addr = BASE + 32'h1000 + 32'($urandom_range(0, 64));
         else if (sel == 1) addr = BASE - 32'($urandom_range(1, 64));
         else               addr = BASE + 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 1) == 0) addr = addr & ~32'h3;
         run_burst("random", 8'($urandom), addr, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'b1,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : -1,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : -1,
                   $urandom_range(0, 3));
      end
   endtask

   task automatic test_reset_mid_burst();
      bit hs;
      aw_id = 8'h77; aw_addr = BASE + 32'h40; aw_len = 4'd7; aw_size = 3'd2; aw_burst = 2'd1;
      aw_valid = 1'b1; hs = 1'b0;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge clock); hs = aw_ready; @(posedge clock); #1;
      end
      aw_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         w_id = 8'h77; w_data = 32'($urandom); w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
         hs = 1'b0;
         for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge clock); hs = w_ready; @(posedge clock); #1;
         end
      end
      #1 reset_n = 1'b0;
      #1;
      obs_q.delete();
      n_cmp++;
      if ({aw_ready, w_ready, b_valid, b_resp, b_id, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
         n_err++; $display("FAIL midreset outputs: got %b/%b/%b/%h/%h/%b/%h/%h/%h need all 0",
                           aw_ready, w_ready, b_valid, b_resp, b_id, mem_we, mem_addr, mem_wdata, mem_be);
      end
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if ({aw_ready, w_ready} !== 2'b10) begin
         n_err++; $display("FAIL midreset first_edge aw/w: got %b need 10", {aw_ready, w_ready});
      end
      for (int c = 0; c < 4; c++) begin @(posedge clock); #1; end
      w_valid = 1'b0;
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++; $display("FAIL midreset stray_writes: got %0d need 0", obs_q.size());
      end
      run_burst("after_reset", 8'h78, BASE + 32'h60, 4'd2, 3'd2, 2'd1, 1'b1, -1, -1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
      aw_lock = '0; aw_cache = '0; aw_prot = '0; aw_user = '0; aw_valid = 1'b0;
      w_id = '0; w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
      test_reset();
      test_incr();
      test_fixed();
      test_wrap();
      test_errors();
      test_bready_stall();
      test_back_to_back();
      test_random();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 The block SHALL have parameter AXI_WR_ID_WIDTH, default 8, for the ID width of the aw/w/b channels.
REQ-002 The block SHALL have parameter AXI_WR_ADDR_WIDTH, default 32, for the aw_addr width.
REQ-003 The block SHALL have parameter AXI_WR_BUS_WIDTH, default 32, for the w_data width; legal values are 32, 64 and 128.
REQ-004 The block SHALL have parameter MEM_ADDR_WIDTH, default 10, for the memory word-index width.
REQ-005 The block SHALL have parameter BASE_ADDR, default 0, for the byte address mapped to memory word 0.
REQ-006 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clock  in  1  clock
  reset_n  in  1  reset, asynchronous, active-low
  aw_id  in  AXI_WR_ID_WIDTH  write address ID
  aw_addr  in  AXI_WR_ADDR_WIDTH  burst start byte address
  aw_len  in  4  beats-1
  aw_size  in  3  bytes per beat = 2^aw_size
  aw_burst  in  2  0 FIXED, 1 INCR, 2 WRAP
  aw_lock, aw_cache, aw_prot, aw_user  in  2/4/3/5  accepted, ignored
  aw_valid  in  1;  aw_ready  out  1
  w_id  in  AXI_WR_ID_WIDTH;  w_data  in  AXI_WR_BUS_WIDTH;  w_strb  in  AXI_WR_BUS_WIDTH/8
  w_last  in  1;  w_valid  in  1;  w_ready  out  1
  b_id  out  AXI_WR_ID_WIDTH;  b_resp  out  2;  b_valid  out  1;  b_ready  in  1
  mem_we  out  1  memory write strobe, one cycle
  mem_addr  out  MEM_ADDR_WIDTH  memory word index
  mem_wdata  out  AXI_WR_BUS_WIDTH  memory write data
  mem_be  out  AXI_WR_BUS_WIDTH/8  memory byte enables

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, DATA and RESP; only one transaction is outstanding at a time.
REQ-008 In IDLE, aw_ready SHALL be 1; on aw_valid&&aw_ready the block SHALL latch id, addr, len, size and burst, drop aw_ready, raise w_ready, clear beat_cnt and err, and enter DATA.
REQ-009 err SHALL be set at AW accept on any of: address outside [BASE_ADDR, BASE_ADDR + 2^MEM_ADDR_WIDTH * bus bytes); 2^aw_size > bus bytes; aw_burst == 3.
REQ-010 In DATA, each w_valid&&w_ready beat SHALL register mem_addr = (cur_addr-BASE_ADDR)/bus bytes, mem_wdata = w_data and mem_be = w_strb, giving a one-cycle latency.
REQ-011 For each beat, mem_we SHALL be set to 1 when err is clear and w_strb != 0, and to 0 otherwise; mem_we is a pulse of exactly one cycle.
REQ-012 The address after a beat SHALL be: FIXED unchanged; INCR = (cur_addr aligned down to 2^size) + 2^size; WRAP per REQ-021.
REQ-013 If an INCR burst crosses the top of the window mid-burst, err SHALL be set, and that beat and all later beats SHALL NOT write memory.
REQ-014 err SHALL be set if w_last != (beat_cnt == len), or if w_id != latched id; the beat count is governed by aw_len only.
REQ-015 On the beat where beat_cnt == len, the block SHALL drop w_ready, set b_valid=1, b_id=latched id and b_resp = err ? 2 (SLVERR) : 0 (OKAY), and enter RESP.
REQ-016 In RESP, b_valid SHALL hold until b_ready; on that handshake b_valid drops, aw_ready rises and the FSM enters IDLE.
REQ-017 The block SHALL sustain one W beat per cycle; the next AW SHALL be accepted no earlier than the cycle after the B handshake.
REQ-018 Signals SHALL NOT depend combinationally on valid or ready inputs; all outputs are registered.

Reset
REQ-019 On reset_n low, the block SHALL clear aw_ready, w_ready, b_valid, b_resp, b_id, mem_we, mem_addr, mem_wdata, mem_be, beat_cnt and err, and go to IDLE immediately, including mid-burst.
REQ-020 aw_ready SHALL assert on the first clock edge after reset_n is released; no write of an aborted burst occurs after reset.

Configuration
REQ-021 With AXI_WR_SLAVE_WRAP_EN defined, WRAP SHALL be supported: wrap boundary = (len+1)*2^size; next addr = lower boundary + ((cur_addr + 2^size) mod boundary size); an unaligned start, or len not in {1,3,7,15}, sets err.
REQ-022 Without AXI_WR_SLAVE_WRAP_EN, aw_burst == 2 SHALL set err, so all beats are accepted, none are written, and b_resp = 2.

Verification
REQ-023 INCR, addr=BASE+0x10, len=3, size=2, strb=0xF, data 1..4 -> mem_we on word idx 4,5,6,7 with data 1..4, then b_resp=0 and b_id=aw_id.
REQ-024 FIXED, len=2, addr=BASE+0x8 -> three writes to idx 2, then b_resp=0.
REQ-025 WRAP (macro on), addr=BASE+0x38, len=3, size=2 -> idx 14,15,12,13; with the macro off -> no mem_we and b_resp=2.
REQ-026 addr=BASE+4*2^MEM_ADDR_WIDTH, len=0 -> no mem_we, b_resp=2; w_last=1 on beat 1 of len=3 -> 4 beats accepted, b_resp=2.
REQ-027 b_ready held low 5 cycles -> b_valid stays 1, aw_ready stays 0; reset_n pulsed after beat 2 of len=7 -> all outputs 0, aw_ready=1 the next cycle.
